// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared FSM encoding and RTC register map for the RTC sequencer
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } rtc_state_e;

  // Time register map; CH (clock halt) lives in the seconds register.
  localparam int REG_SEC    = 0;
  localparam int REG_MIN    = 1;
  localparam int REG_HOUR   = 2;
  localparam int REG_DAY    = 3;
  localparam int REG_DATE   = 4;
  localparam int REG_MONTH  = 5;
  localparam int REG_YEAR   = 6;
  localparam int CH_BIT     = 7;

  localparam int DEF_NBYTES = 7;
  localparam int BYTE_W     = 8;

  function automatic int byte_lsb(input int k);
    return k * BYTE_W;
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtl/rtc_tick_gen.sv - free-running period counter emitting a one-cycle tick on wrap
module rtc_tick_gen #(
  parameter int PERIOD = 5_000_000
) (
  input  logic sysclk,
  input  logic rstn,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rtc_ctrl.sv
// rtl/rtc_ctrl.sv - IIC transaction sequencer: periodic RTC time polls and prioritised set-time writes
module rtc_ctrl import rtc_pkg::*; #(
  parameter int          SYSCLK_FREQ    = 50_000_000,
  parameter int          POLL_HZ        = 10,
  parameter logic [6:0]  RTC_ADDR       = 7'h68,
  parameter logic [7:0]  REG_BASE       = 8'h00,
  parameter int          NBYTES         = DEF_NBYTES,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  sysclk,
  input  logic                  rstn,
  input  logic                  set_req,
  input  logic [8*NBYTES-1:0]   set_time,
  output logic                  set_ack,
  output logic [8*NBYTES-1:0]   rtc_time,
  output logic                  time_valid,
  output logic                  err_timeout,
  output logic                  iic_req,
  output logic                  iic_mode,
  output logic [6:0]            iic_addr_divice,
  output logic [15:0]           iic_addr_reg,
  output logic [7:0]            iic_wr_data,
  output logic [15:0]           iic_wr_length,
  output logic [15:0]           iic_rd_length,
  input  logic                  iic_busy,
  input  logic                  iic_done,
  input  logic                  iic_wr_valid,
  input  logic                  iic_rd_valid,
  input  logic [7:0]            iic_rd_data
);

  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NBYTES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  rtc_state_e            state, state_nxt;
  logic                  poll_tick;
  logic                  set_pend, poll_pend, set_accept;
  logic [8*NBYTES-1:0]   set_buf, shadow;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_hit, in_wait;
  logic                  ack_nxt, tv_nxt, err_nxt, load_time;

  rtc_tick_gen #(.PERIOD(SYSCLK_FREQ / POLL_HZ)) u_poll_tick (
    .sysclk (sysclk),
    .rstn   (rstn),
    .tick   (poll_tick)
  );

  assign iic_addr_divice = RTC_ADDR;
  assign iic_addr_reg    = {8'h00, REG_BASE};
  assign iic_wr_length   = 16'(NBYTES);
  assign iic_rd_length   = 16'(NBYTES);
  assign iic_wr_data     = set_buf[byte_lsb(int'(wr_idx)) +: BYTE_W];

  assign in_wait    = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
  assign wd_hit     = (wd_cnt == WD_LAST);
  // A request arriving while a write is on the bus could corrupt the bytes being sent.
  assign set_accept = set_req && !set_pend && (state != ST_WR_WAIT);

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    tv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    load_time = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!iic_busy) begin
          if (set_pend)       state_nxt = ST_WR_REQ;
          else if (poll_pend) state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_REQ: state_nxt = ST_WR_WAIT;
      ST_RD_REQ: state_nxt = ST_RD_WAIT;
      ST_WR_WAIT: begin
        if (iic_done) begin
          ack_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (iic_done) begin
          // A short read never reaches rtc_time; it is reported like a timeout.
          if (rd_idx == FULL_IDX) begin
            tv_nxt    = 1'b1;
            load_time = 1'b1;
          end else begin
            err_nxt   = 1'b1;
          end
          state_nxt = ST_IDLE;
        end else if (wd_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      iic_req     <= 1'b0;
      iic_mode    <= 1'b0;
      set_ack     <= 1'b0;
      time_valid  <= 1'b0;
      err_timeout <= 1'b0;
      rtc_time    <= '0;
      shadow      <= '0;
      set_buf     <= '0;
      set_pend    <= 1'b0;
      poll_pend   <= 1'b0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      wd_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      iic_req     <= (state == ST_WR_REQ) || (state == ST_RD_REQ);
      set_ack     <= ack_nxt;
      time_valid  <= tv_nxt;
      err_timeout <= err_nxt;
      if (state == ST_WR_REQ)      iic_mode <= 1'b0;
      else if (state == ST_RD_REQ) iic_mode <= 1'b1;
      if (load_time) rtc_time <= shadow;

      if (set_accept) set_buf <= set_time;
      if (state == ST_WR_REQ) set_pend <= 1'b0;
      else if (set_accept)    set_pend <= 1'b1;
      if (state == ST_RD_REQ) poll_pend <= 1'b0;
      else if (poll_tick)     poll_pend <= 1'b1;

      if (state == ST_WR_REQ) begin
        wr_idx <= '0;
      end else if (state == ST_WR_WAIT && iic_wr_valid && wr_idx != LAST_IDX) begin
        wr_idx <= wr_idx + 1'b1;
      end

      if (state == ST_RD_REQ) begin
        rd_idx <= '0;
      end else if (state == ST_RD_WAIT && iic_rd_valid && rd_idx != FULL_IDX) begin
        shadow[byte_lsb(int'(rd_idx)) +: BYTE_W] <= iic_rd_data;
        rd_idx <= rd_idx + 1'b1;
      end

      wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
    end
  end

endmodule
